// File: rtl/udp_echo_app_pkg.sv
// Shared types and widths for the UDP echo app.
// Holds the TX control state encoding and the flit mux select.
package udp_echo_app_pkg;

  localparam int NOC_DATA_BYTES   = 64;
  localparam int NOC_DATA_BYTES_W = 6;
  localparam int MSG_LENGTH_WIDTH = 8;
  localparam int UDP_LENGTH_W     = 16;

  typedef enum logic [2:0] {
    READY,
    HDR_FLIT,
    META_FLIT,
    DATA_PASSTHRU
  } out_state_e;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    META = 2'd1,
    DATA = 2'd2
  } flit_sel_e;

endpackage

// File: rtl/udp_echo_app_out_ctrl.sv
// TX control FSM: emits header, meta, then data flits to the UDP TX engine.
// Ports: descriptor handshake, source data handshake, NoC val/rdy, mux select, stats.
module udp_echo_app_out_ctrl
  import udp_echo_app_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hdr_meta_val,
  output logic                        hdr_meta_rdy,
  input  logic                        src_data_val,
  output logic                        src_data_rdy,
  output logic                        udp_app_out_noc0_vrtoc_val,
  input  logic                        noc0_vrtoc_udp_app_out_rdy,
  output logic [1:0]                  out_flit_sel,
  input  logic [MSG_LENGTH_WIDTH-1:0] total_flits,
  input  logic [UDP_LENGTH_W-1:0]     data_length,
  output logic                        out_done,
  output logic                        app_stats_do_log,
  output logic                        app_stats_incr_bytes_sent,
  output logic [NOC_DATA_BYTES_W:0]   app_stats_num_bytes_sent
);

  localparam logic [NOC_DATA_BYTES_W:0] FULL_BYTES =
    (NOC_DATA_BYTES_W+1)'(NOC_DATA_BYTES);

  out_state_e                  state_q, state_d;
  logic [MSG_LENGTH_WIDTH-1:0] cnt_q, cnt_d;
  logic                        do_log_q, do_log_d;

  logic      meta_rdy_c, src_rdy_c, val_c;
  logic      done_c, incr_c;
  flit_sel_e sel_c;
  logic      noc_rdy, last_flit;

  logic [NOC_DATA_BYTES_W-1:0] tail_bytes;
  logic [NOC_DATA_BYTES_W:0]   num_bytes_c;
  logic                        unused_len;

  assign noc_rdy    = noc0_vrtoc_udp_app_out_rdy;
  assign last_flit  = (cnt_q == total_flits);
  assign tail_bytes = data_length[NOC_DATA_BYTES_W-1:0];
  assign unused_len = ^data_length[UDP_LENGTH_W-1:NOC_DATA_BYTES_W];

  // A partial last flit reports its remainder; an exact multiple reports full.
  assign num_bytes_c = (last_flit && (tail_bytes != '0))
                     ? {1'b0, tail_bytes}
                     : FULL_BYTES;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= READY;
      cnt_q    <= '0;
      do_log_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      do_log_q <= do_log_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    do_log_d   = do_log_q;
    meta_rdy_c = 1'b0;
    src_rdy_c  = 1'b0;
    val_c      = 1'b0;
    done_c     = 1'b0;
    incr_c     = 1'b0;
    sel_c      = HDR;
    case (state_q)
      READY: begin
        meta_rdy_c = 1'b1;
        cnt_d      = '0;
        if (hdr_meta_val) begin
          do_log_d = 1'b1;
          state_d  = HDR_FLIT;
        end
      end
      HDR_FLIT: begin
        val_c = 1'b1;
        if (noc_rdy) begin
          cnt_d   = MSG_LENGTH_WIDTH'(1);
          state_d = META_FLIT;
        end
      end
      META_FLIT: begin
        val_c = 1'b1;
        sel_c = META;
        if (noc_rdy) begin
          cnt_d = cnt_q + 1'b1;
          if (last_flit) begin
            done_c  = 1'b1;
            cnt_d   = '0;
            state_d = READY;
          end else begin
            state_d = DATA_PASSTHRU;
          end
        end
      end
      DATA_PASSTHRU: begin
        sel_c     = DATA;
        val_c     = src_data_val;
        src_rdy_c = noc_rdy;
        if (src_data_val && noc_rdy) begin
          incr_c = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (last_flit) begin
            done_c  = 1'b1;
            cnt_d   = '0;
            state_d = READY;
          end
        end
      end
      default: begin
        state_d    = out_state_e'(3'bxxx);
        cnt_d      = 'x;
        do_log_d   = 1'bx;
        meta_rdy_c = 1'bx;
        src_rdy_c  = 1'bx;
        val_c      = 1'bx;
        done_c     = 1'bx;
        incr_c     = 1'bx;
        sel_c      = flit_sel_e'(2'bxx);
      end
    endcase
  end

  // Reset forces every output low, including READY's hdr_meta_rdy.
  assign hdr_meta_rdy               = meta_rdy_c & ~rst;
  assign src_data_rdy               = src_rdy_c & ~rst;
  assign udp_app_out_noc0_vrtoc_val = val_c & ~rst;
  assign out_flit_sel               = rst ? 2'd0 : sel_c;
  assign out_done                   = done_c & ~rst;
  assign app_stats_do_log           = do_log_q & ~rst;
  assign app_stats_incr_bytes_sent  = incr_c & ~rst;
  assign app_stats_num_bytes_sent   = rst ? '0 : num_bytes_c;

endmodule

// File: tb/tb_udp_echo_app_out_ctrl.sv
// Self-checking bench for udp_echo_app_out_ctrl.
// Scoreboard of expected flits, random backpressure and source gaps.
module tb_udp_echo_app_out_ctrl;
  import udp_echo_app_pkg::*;

  logic clk = 0;
  logic rst = 1;
  logic hdr_meta_val = 0;
  logic hdr_meta_rdy;
  logic src_data_val = 0;
  logic src_data_rdy;
  logic noc_val;
  logic noc_rdy = 0;
  logic [1:0] sel;
  logic [MSG_LENGTH_WIDTH-1:0] total_flits = 0;
  logic [UDP_LENGTH_W-1:0] data_length = 0;
  logic out_done;
  logic do_log;
  logic incr;
  logic [NOC_DATA_BYTES_W:0] nbytes;

  udp_echo_app_out_ctrl dut (
    .clk(clk),
    .rst(rst),
    .hdr_meta_val(hdr_meta_val),
    .hdr_meta_rdy(hdr_meta_rdy),
    .src_data_val(src_data_val),
    .src_data_rdy(src_data_rdy),
    .udp_app_out_noc0_vrtoc_val(noc_val),
    .noc0_vrtoc_udp_app_out_rdy(noc_rdy),
    .out_flit_sel(sel),
    .total_flits(total_flits),
    .data_length(data_length),
    .out_done(out_done),
    .app_stats_do_log(do_log),
    .app_stats_incr_bytes_sent(incr),
    .app_stats_num_bytes_sent(nbytes)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int bytes;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int mode = 0;
  int accepts = 0;
  int pkts = 0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int flits_for(int dl);
    return 1 + (dl + NOC_DATA_BYTES - 1) / NOC_DATA_BYTES;
  endfunction

  // Reference: one HDR, one META, then ceil(dl/64) data flits.
  function automatic void push_exp(int dl);
    int nd;
    exp_t e;
    nd = (dl + NOC_DATA_BYTES - 1) / NOC_DATA_BYTES;
    e.sel = 0; e.bytes = 0; e.done = 0;
    exp_q.push_back(e);
    e.sel = 1; e.done = (nd == 0);
    exp_q.push_back(e);
    for (int k = 1; k <= nd; k++) begin
      e.sel = 2;
      e.done = (k == nd);
      if (k < nd || dl % NOC_DATA_BYTES == 0) e.bytes = NOC_DATA_BYTES;
      else e.bytes = dl % NOC_DATA_BYTES;
      exp_q.push_back(e);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    case (mode)
      0: begin noc_rdy = 1; src_data_val = 1; end
      1: begin noc_rdy = ~noc_rdy; src_data_val = ($urandom % 3) != 0; end
      default: begin
        noc_rdy = $urandom % 2;
        src_data_val = ($urandom % 4) != 0;
      end
    endcase
  end

  // Monitor
  bit prev_stall = 0;
  int prev_sel = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (hdr_meta_rdy && hdr_meta_val) accepts++;
      if (prev_stall) begin
        chk("stall_sel", sel, prev_sel);
        if (prev_sel != 2) chk("stall_val", noc_val, 1);
      end
      chk("src_rdy", src_data_rdy, (sel == 2) && noc_rdy);
      if (noc_val && noc_rdy) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_flit: sel %0d with empty scoreboard", sel);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("flit_sel", sel, e.sel);
          chk("flit_done", out_done, e.done);
          chk("flit_incr", incr, e.sel == 2);
          if (e.sel == 2) chk("flit_bytes", nbytes, e.bytes);
        end
      end else begin
        chk("idle_done", out_done, 0);
        chk("idle_incr", incr, 0);
      end
      prev_stall = noc_val && !noc_rdy;
      prev_sel = sel;
    end
  end

  task automatic zero_outs(string name);
    chk(name, {hdr_meta_rdy, src_data_rdy, noc_val, sel,
               out_done, do_log, incr, nbytes}, 0);
  endtask

  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (hdr_meta_rdy) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: hdr_meta_rdy 0 expected 1");
    end
  endtask

  task automatic wait_done_neg(output int cyc);
    bit ok = 0;
    cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cyc++;
      if (out_done) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_timeout: out_done 0 expected 1");
    end
  endtask

  task automatic send_pkt(int dl, bit timed);
    int cyc;
    data_length = UDP_LENGTH_W'(dl);
    total_flits = MSG_LENGTH_WIDTH'(flits_for(dl));
    hdr_meta_val = 1;
    push_exp(dl);
    pkts++;
    wait_accept();
    wait_done_neg(cyc);
    if (timed) chk("latency", cyc, flits_for(dl) + 1);
    @(posedge clk); #1;
    hdr_meta_val = 0;
  endtask

  initial begin
    int cyc;
    int dl;
    bit ok;
    #2;
    zero_outs("reset_outs");
    #20;
    rst = 0;
    @(posedge clk); #1;
    mode = 0;
    send_pkt(100, 1);
    chk("do_log", do_log, 1);
    send_pkt(128, 1);
    send_pkt(0, 1);
    mode = 1;
    send_pkt(200, 0);
    send_pkt(64, 0);
    mode = 2;
    for (int i = 0; i < 10; i++) send_pkt($urandom_range(0, 300), 0);

    // Back-to-back with hdr_meta_val held high
    mode = 2;
    dl = 150;
    data_length = UDP_LENGTH_W'(dl);
    total_flits = MSG_LENGTH_WIDTH'(flits_for(dl));
    hdr_meta_val = 1;
    push_exp(dl);
    push_exp(dl);
    pkts += 2;
    wait_accept();
    wait_done_neg(cyc);
    @(negedge clk);
    chk("b2b_ready", hdr_meta_rdy, 1);
    @(posedge clk); #1;
    hdr_meta_val = 0;
    @(negedge clk);
    chk("b2b_rdy_low", hdr_meta_rdy, 0);
    chk("b2b_hdr_val", noc_val, 1);
    chk("b2b_hdr_sel", sel, 0);
    wait_done_neg(cyc);
    @(posedge clk); #1;

    // Async reset mid data phase
    dl = 400;
    data_length = UDP_LENGTH_W'(dl);
    total_flits = MSG_LENGTH_WIDTH'(flits_for(dl));
    hdr_meta_val = 1;
    push_exp(dl);
    pkts++;
    wait_accept();
    @(posedge clk); #1;
    hdr_meta_val = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel == 2 && noc_val) begin ok = 1; break; end
    end
    chk("reach_data", ok, 1);
    #2;
    rst = 1;
    #1;
    zero_outs("mid_reset_outs");
    exp_q.delete();
    @(negedge clk);
    #2;
    rst = 0;
    @(negedge clk);
    chk("post_reset_ready", hdr_meta_rdy, 1);
    chk("post_reset_val", noc_val, 0);
    @(posedge clk); #1;
    send_pkt(90, 0);
    chk("do_log_again", do_log, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    chk("accepts", accepts, pkts);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
